// File: rtl/alu_serial_addsub_if.sv
// alu_serial_addsub_if: start/done handshake, operands, result and
// condition-code bundle for the serial add/subtract unit.
// master = requester (execute stage), slave = the arithmetic unit.
interface alu_serial_addsub_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             of;
    logic             cf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zf, sf, of, cf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zf, sf, of, cf
    );
endinterface

// File: rtl/alu_serial_addsub.sv
// alu_serial_addsub: multi-cycle add/sub (and optionally and/xor) unit that
// processes CHUNK bits per clock, LSB slice first, carrying between slices
// in a register, and produces y86-64 condition codes on completion.
// Optional macro ALU_SERIAL_LOGIC_OPS_EN enables op 2 (and) / op 3 (xor);
// without it only op[0] is decoded (op 2 = add, op 3 = sub).
module alu_serial_addsub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_serial_addsub_if.slave   bus
);
    localparam int K  = WIDTH / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;        // b, already inverted for subtraction
    logic [WIDTH-1:0] r_work;     // slice-by-slice working result
    logic [WIDTH-1:0] r_result;   // visible result, updated only on completion
    logic             r_sub;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;
    logic             r_cf;
`ifdef ALU_SERIAL_LOGIC_OPS_EN
    logic             r_logic;
    logic             r_xor;
`endif

    logic             w_accept;
    logic             w_last;
    logic             w_is_sub_in;
    logic             w_is_logic;
    logic [CHUNK-1:0] w_a_sl [K];
    logic [CHUNK-1:0] w_b_sl [K];
    logic [CHUNK-1:0] w_a_cur;
    logic [CHUNK-1:0] w_b_cur;
    logic [CHUNK:0]   w_sum;
    logic [CHUNK-1:0] w_slice;
    logic [WIDTH-1:0] w_final;
    logic             w_of;
    logic             w_cf;

    // Start is ignored only while slices are in flight; DONE accepts back-to-back.
    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_idx == IW'(K - 1));

`ifdef ALU_SERIAL_LOGIC_OPS_EN
    assign w_is_sub_in = (bus.op == 2'd1);
    assign w_is_logic  = r_logic;
`else
    assign w_is_sub_in = bus.op[0];
    assign w_is_logic  = 1'b0;
`endif

    // Slice views of the latched operands and the merged working word.
    for (genvar gi = 0; gi < K; gi++) begin : g_slice
        assign w_a_sl[gi] = r_a[gi*CHUNK +: CHUNK];
        assign w_b_sl[gi] = r_b[gi*CHUNK +: CHUNK];
        assign w_final[gi*CHUNK +: CHUNK] =
            (r_idx == IW'(gi)) ? w_slice : r_work[gi*CHUNK +: CHUNK];
    end

    assign w_a_cur = w_a_sl[r_idx];
    assign w_b_cur = w_b_sl[r_idx];
    assign w_sum   = {1'b0, w_a_cur} + {1'b0, w_b_cur} + {{CHUNK{1'b0}}, r_carry};

    // Per-slice result: adder output, or the bitwise op when enabled.
    always_comb begin
        w_slice = w_sum[CHUNK-1:0];
`ifdef ALU_SERIAL_LOGIC_OPS_EN
        if (r_logic) begin
            w_slice = r_xor ? (w_a_cur ^ w_b_cur) : (w_a_cur & w_b_cur);
        end
`endif
    end

    // r_b holds ~b for sub, so "b_msb differs from a_msb" becomes "b'_msb matches".
    assign w_of = !w_is_logic && (r_a[WIDTH-1] == r_b[WIDTH-1])
                              && (w_final[WIDTH-1] != r_a[WIDTH-1]);
    assign w_cf = !w_is_logic && (w_sum[CHUNK] ^ r_sub);

    // Control FSM, operand latch, slice datapath and completion flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
            r_cf     <= 1'b0;
`ifdef ALU_SERIAL_LOGIC_OPS_EN
            r_logic  <= 1'b0;
            r_xor    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= w_is_sub_in ? ~bus.b : bus.b;
                r_sub   <= w_is_sub_in;
                r_carry <= w_is_sub_in;
                r_idx   <= '0;
`ifdef ALU_SERIAL_LOGIC_OPS_EN
                r_logic <= bus.op[1];
                r_xor   <= bus.op[0];
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) r_state <= S_RUN;
                end
                S_RUN: begin
                    r_work  <= w_final;
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_result <= w_final;
                        r_zf     <= (w_final == '0);
                        r_sf     <= w_final[WIDTH-1];
                        r_of     <= w_of;
                        r_cf     <= w_cf;
                    end
                end
                S_DONE: begin
                    r_state <= bus.start ? S_RUN : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.zf     = r_zf;
    assign bus.sf     = r_sf;
    assign bus.of     = r_of;
    assign bus.cf     = r_cf;
endmodule

// File: tb/tb_alu_serial_addsub.sv
// tb_alu_serial_addsub: self-checking bench for alu_serial_addsub with
// WIDTH=64, CHUNK=16 (K=4). Honours ALU_SERIAL_LOGIC_OPS_EN when defined.
module tb_alu_serial_addsub;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int K     = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             zf;
        logic             sf;
        logic             of;
        logic             cf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: whole-word arithmetic on the architectural definition.
    function automatic res_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        res_t         m;
        logic [WIDTH:0] full;
        logic         is_sub;
        m = '0;
`ifdef ALU_SERIAL_LOGIC_OPS_EN
        is_sub = (op == 2'd1);
`else
        is_sub = op[0];
`endif
        if (is_sub) begin
            m.r  = a - b;
            m.cf = (a < b);
            m.of = (a[WIDTH-1] != b[WIDTH-1]) && (m.r[WIDTH-1] != a[WIDTH-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            m.r  = full[WIDTH-1:0];
            m.cf = full[WIDTH];
            m.of = (a[WIDTH-1] == b[WIDTH-1]) && (m.r[WIDTH-1] != a[WIDTH-1]);
        end
`ifdef ALU_SERIAL_LOGIC_OPS_EN
        if (op[1]) begin
            m.r  = (op == 2'd2) ? (a & b) : (a ^ b);
            m.of = 1'b0;
            m.cf = 1'b0;
        end
`endif
        m.zf = (m.r == '0);
        m.sf = m.r[WIDTH-1];
        return m;
    endfunction

    function automatic res_t observed();
        res_t g;
        g.r  = bus.result;
        g.zf = bus.zf;
        g.sf = bus.sf;
        g.of = bus.of;
        g.cf = bus.cf;
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Present one request; returns at acceptance edge + 1, inputs scrambled.
    task automatic accept(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = rnd64();
        bus.b     = rnd64();
    endtask

    // Bounded wait for done; n = edges elapsed, nbusy = samples with busy high.
    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) nbusy++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, observed()} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h required all zero",
                     bus.busy, bus.done, observed());
        end
        $display("txn reset busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]       ops [4]  = '{2'd1, 2'd1, 2'd1, 2'd0};
        logic [WIDTH-1:0] as  [4]  = '{64'd999999999, 64'd3, 64'd5, 64'h7FFF_FFFF_FFFF_FFFF};
        logic [WIDTH-1:0] bs  [4]  = '{64'd12345, 64'd10, 64'd5, 64'd1};
        res_t             exp [4]  = '{{64'd999987654, 4'b0000},
                                       {64'hFFFF_FFFF_FFFF_FFF9, 4'b0101},
                                       {64'd0, 4'b1000},
                                       {64'h8000_0000_0000_0000, 4'b0110}};
        int n, nb;
        for (int i = 0; i < 4; i++) begin
            accept(ops[i], as[i], bs[i]);
            wait_done(n, nb);
            $display("txn directed op=%0d a=%h b=%h result=%h zsoc=%b%b%b%b after %0d",
                     ops[i], as[i], bs[i], bus.result, bus.zf, bus.sf, bus.of, bus.cf, n);
            n_cmp++;
            if (n !== K) begin
                n_bad++;
                $display("FAIL directed_latency[%0d]: got %0d cycles required %0d", i, n, K);
            end
            n_cmp++;
            if (nb !== K) begin
                n_bad++;
                $display("FAIL directed_busy_len[%0d]: got %0d required %0d", i, nb, K);
            end
            n_cmp++;
            if (observed() !== exp[i]) begin
                n_bad++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, observed(), exp[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL done_pulse_width[%0d]: got done=%b required 0", i, bus.done);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] corner [4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                                         64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b;
        res_t             exp;
        int n, nb;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : rnd64();
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : rnd64();
            exp = model(op, a, b);
            accept(op, a, b);
            wait_done(n, nb);
            $display("txn random op=%0d a=%h b=%h result=%h zsoc=%b%b%b%b",
                     op, a, b, bus.result, bus.zf, bus.sf, bus.of, bus.cf);
            n_cmp++;
            if (n !== K) begin
                n_bad++;
                $display("FAIL random_latency[%0d]: got %0d required %0d", i, n, K);
            end
            n_cmp++;
            if (observed() !== exp) begin
                n_bad++;
                $display("FAIL random_result[%0d]: got %h required %h", i, observed(), exp);
            end
        end
    endtask

    task automatic test_ignore_and_abort();
        int n, nb, extra;
        res_t exp;
        exp = '{r: 64'd7, zf: 1'b0, sf: 1'b0, of: 1'b0, cf: 1'b0};
        accept(2'd1, 64'd10, 64'd3);
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 64'd1;
        bus.b     = 64'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n, nb);
        $display("txn ignore op=1 a=10 b=3 result=%h after %0d", bus.result, n + 2);
        n_cmp++;
        if (n + 2 !== K) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d required %0d", n + 2, K);
        end
        n_cmp++;
        if (observed() !== exp) begin
            n_bad++;
            $display("FAIL ignore_result: got %h required %h", observed(), exp);
        end
        extra = 0;
        for (int i = 0; i < 2 * K; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL ignore_no_extra_op: got %0d active cycles required 0", extra);
        end
        // Fresh op, reset asserted during its third RUN cycle.
        accept(2'd0, rnd64(), rnd64());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, observed()} !== '0) begin
            n_bad++;
            $display("FAIL abort_state: got busy=%b done=%b res=%h required all zero",
                     bus.busy, bus.done, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 2 * K; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        $display("txn abort busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d active cycles required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a1, b1, a2, b2;
        logic [1:0]       op1, op2;
        res_t             exp1, exp2;
        int n, nb;
        for (int i = 0; i < 3; i++) begin
            op1 = 2'($urandom_range(0, 3));
            op2 = 2'($urandom_range(0, 3));
            a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
            exp1 = model(op1, a1, b1);
            exp2 = model(op2, a2, b2);
            accept(op1, a1, b1);
            wait_done(n, nb);
            n_cmp++;
            if (observed() !== exp1) begin
                n_bad++;
                $display("FAIL b2b_first[%0d]: got %h required %h", i, observed(), exp1);
            end
            // Still in the DONE cycle: request the next op immediately.
            bus.start = 1'b1;
            bus.op    = op2;
            bus.a     = a2;
            bus.b     = b2;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            wait_done(n, nb);
            $display("txn b2b op=%0d a=%h b=%h result=%h gap=%0d", op2, a2, b2, bus.result, n + 1);
            n_cmp++;
            if (n + 1 !== K + 1) begin
                n_bad++;
                $display("FAIL b2b_gap[%0d]: got %0d required %0d", i, n + 1, K + 1);
            end
            n_cmp++;
            if (observed() !== exp2) begin
                n_bad++;
                $display("FAIL b2b_second[%0d]: got %h required %h", i, observed(), exp2);
            end
        end
    endtask

    task automatic test_logic_ops();
`ifdef ALU_SERIAL_LOGIC_OPS_EN
        logic [WIDTH-1:0] exp_r [2] = '{64'h30, 64'hCC};
`else
        logic [WIDTH-1:0] exp_r [2] = '{64'h12C, 64'hB4};
`endif
        int n, nb;
        for (int i = 0; i < 2; i++) begin
            accept(2'(i + 2), 64'hF0, 64'h3C);
            wait_done(n, nb);
            $display("txn logic op=%0d a=f0 b=3c result=%h of=%b cf=%b", i + 2,
                     bus.result, bus.of, bus.cf);
            n_cmp++;
            if (bus.result !== exp_r[i] || bus.of !== 1'b0 || bus.cf !== 1'b0) begin
                n_bad++;
                $display("FAIL logic_op[%0d]: got %h of=%b cf=%b required %h of=0 cf=0",
                         i + 2, bus.result, bus.of, bus.cf, exp_r[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_abort();
        test_back_to_back();
        test_logic_ops();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_serial_addsub.md
# alu_serial_addsub

Parametrised, multi-cycle add/subtract unit, the sequential successor to the fixed 64-bit combinational subtractor in the ALU. It processes the operands in CHUNK-bit slices, one slice per clock, and carries between slices in a register. It also produces the y86-64 condition codes. It sits in the execute stage wherever area matters more than single-cycle latency, behind a start/done handshake.

## Interface
- WIDTH, 64, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 16, bits processed per cycle; K = WIDTH/CHUNK slice cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; the only clock is clk.
- start  in  1  request; accepted only when not busy.
- op  in  2  0 = add (a+b), 1 = sub (a-b), 2 = and, 3 = xor (see Configuration).
- a  in  WIDTH  first operand, sampled on acceptance.
- b  in  WIDTH  second operand, sampled on acceptance.
- busy  out  1  high while slices are being computed.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  last completed result, held until the next completion.
- zf, sf, of, cf  out  1 each  zero, sign, signed-overflow and carry/borrow flags of the last completed op.

## Operation
- States:
  - IDLE: on start=1, go to RUN.
  - RUN: stays K cycles, then goes to DONE.
  - DONE: lasts one cycle, then goes to IDLE. If start=1 in DONE, go straight to RUN (back-to-back).
- Acceptance latches a, op, and b' = (op==1) ? ~b : b. It sets carry = (op==1) and clears the slice index.
- RUN, each cycle for slice k (LSB first):
  - {c, s} = a[k] + b'[k] + carry, each slice CHUNK bits wide.
  - Write s into result slice k, register c, then increment k.
- The result register is a separate working register. The visible result is updated only on the transition into DONE.
- Arithmetic wraps modulo 2^WIDTH. Operands are treated as two's-complement signed.
- Flags are updated only on the transition into DONE:
  - zf = (result == 0).
  - sf = result[WIDTH-1].
  - add: of = (a_msb == b_msb) && (r_msb != a_msb); cf = final carry out.
  - sub: of = (a_msb != b_msb) && (r_msb != a_msb); cf = ~final carry out, i.e. borrow, 1 when a < b unsigned.
  - and/xor: of = 0, cf = 0; computed slice-wise with the same latency.
- start while busy=1 is ignored; no queueing.
- done=1 exactly in DONE; busy=1 exactly in RUN.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, result=0, zf=sf=of=cf=0, internal carry/index cleared.
- Reset mid-RUN aborts the operation. No done pulse follows, and outputs take their reset values.
- start sampled high at edge E0 (accepted): busy=1 from E0 to E0+K; done=1 and new result/flags from E0+K to E0+K+1.
  - Latency from acceptance to done is K cycles. With defaults K=4.
- Back-to-back: start high during the DONE cycle gives the next done exactly K+1 cycles after the previous one.
- Inputs a, b and op may change freely after acceptance without effect.
- The degenerate case CHUNK == WIDTH is legal: K=1, single RUN cycle.

## Configuration
- ALU_SERIAL_LOGIC_OPS_EN
  - Defined: op 2 (and) and op 3 (xor) are implemented as above.
  - Undefined: the logic datapath is removed. Only op[0] is decoded, so op 2 behaves as add and op 3 behaves as sub, with identical timing.

## Test plan
- WIDTH=64, CHUNK=16, sub: a=999999999, b=12345.
  - done exactly 4 cycles after acceptance, result=999987654, zf=0 sf=0 of=0 cf=0, busy high for exactly 4 cycles.
- Sub: a=3, b=10.
  - result=-7 (0xFFFF_FFFF_FFFF_FFF9), sf=1, cf=1, of=0, zf=0.
- Sub a=5, b=5.
  - result=0, zf=1, cf=0.
- Add a=0x7FFF_FFFF_FFFF_FFFF, b=1.
  - result=0x8000_0000_0000_0000, of=1, sf=1, cf=0.
  - Checks carry across all three slice boundaries.
- Issue a=10, b=3, sub; pulse start again in RUN cycle 2 with a=1, b=1; then drop rst_n in RUN cycle 3 of a fresh op.
  - First op: result=7 with no extra done, since the second start is ignored.
  - After reset: busy=0, done never pulses, all outputs 0.
- With ALU_SERIAL_LOGIC_OPS_EN, a=0xF0, b=0x3C: op=2 gives 0x30 and op=3 gives 0xCC, with of=cf=0.
  - Without the macro: op=2 gives 0x12C and op=3 gives 0xB4.
